// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state encoding for the SPI master driver
package spi_pkg;

  localparam int SPI_FRAME_BITS = 8;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - sclk divider and edge counter for the SPI master
// Pulses are combinational so the master registers data on the same clk edge that toggles sclk.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic cpol,
  output logic sclk,
  output logic lead_pulse,
  output logic trail_pulse,
  output logic last_edge
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_cnt;
  logic [3:0]    edge_cnt;
  logic          tick;

  assign tick        = en && (div_cnt == DW'(CLK_DIV - 1));
  // edge_cnt holds edges already made, so an even count means the next edge is odd (leading)
  assign lead_pulse  = tick && !edge_cnt[0];
  assign trail_pulse = tick && edge_cnt[0];
  assign last_edge   = tick && (edge_cnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
    end else if (load) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk     <= cpol;
    end else if (en) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + 4'd1;
      end
    end else begin
      div_cnt <= '0;
    end
  end

endmodule

// File: rtl/spi_master_driver.sv
// rtl/spi_master_driver.sv - full-duplex 8-bit SPI master, modes 0-3 per transfer
module spi_master_driver
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SPI_FRAME_BITS-1:0] tx_data,
  input  logic [1:0]                mode,
  output logic [SPI_FRAME_BITS-1:0] rx_data,
  output logic                      done,
  output logic                      busy,
  output logic                      sclk,
  output logic                      cs_n,
  output logic                      mosi,
  input  logic                      miso
);

  localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PW     = $clog2(PH_MAX + 1);

  spi_state_e                state, state_next;
  logic [PW-1:0]             ph_cnt;
  logic                      ph_last;
  logic [SPI_FRAME_BITS-1:0] shift_tx, rx_shift;
  logic [3:0]                bit_cnt;
  logic                      cpha_q;
  logic                      lead_pulse, trail_pulse, last_edge;
  logic                      accept;

  assign accept  = (state == ST_IDLE) && start;
  assign ph_last = (state == ST_SETUP) ? (ph_cnt == PW'(CS_SETUP - 1))
                                       : (ph_cnt == PW'(CS_HOLD - 1));

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk         (clk),
    .rst         (rst),
    .en          (state == ST_XFER),
    .load        (accept),
    .cpol        (mode[1]),
    .sclk        (sclk),
    .lead_pulse  (lead_pulse),
    .trail_pulse (trail_pulse),
    .last_edge   (last_edge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      ph_cnt <= '0;
    end else begin
      state  <= state_next;
      ph_cnt <= ((state_next == state) && ((state == ST_SETUP) || (state == ST_HOLD)))
                ? ph_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start)     state_next = ST_SETUP;
      ST_SETUP: if (ph_last)   state_next = ST_XFER;
      ST_XFER:  if (last_edge) state_next = ST_HOLD;
      ST_HOLD:  if (ph_last)   state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      rx_data  <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      shift_tx <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      cpha_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          shift_tx <= tx_data;
          cpha_q   <= mode[0];
          mosi     <= tx_data[SPI_FRAME_BITS-1];
          cs_n     <= 1'b0;
          busy     <= 1'b1;
          bit_cnt  <= '0;
        end
        ST_XFER: begin
          if (cpha_q ? trail_pulse : lead_pulse) begin
            rx_shift <= {rx_shift[SPI_FRAME_BITS-2:0], miso};
            bit_cnt  <= bit_cnt + 4'd1;
          end
          // CPHA=0 already presented bit7 at cs_n fall; the final trailing edge leaves mosi alone
          if (!cpha_q && trail_pulse && (bit_cnt != 4'(SPI_FRAME_BITS))) begin
            mosi     <= shift_tx[SPI_FRAME_BITS-2];
            shift_tx <= {shift_tx[SPI_FRAME_BITS-2:0], 1'b0};
          end
          if (cpha_q && lead_pulse) begin
            mosi     <= shift_tx[SPI_FRAME_BITS-1];
            shift_tx <= {shift_tx[SPI_FRAME_BITS-2:0], 1'b0};
          end
        end
        ST_HOLD: if (ph_last) begin
          cs_n    <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b1;
          rx_data <= rx_shift;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_driver.sv
// tb/tb_spi_master_driver.sv - directed self-checking bench for spi_master_driver
module tb_spi_master_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] mode = 2'b00;
  logic [7:0] rx_data;
  logic       done, busy, sclk, cs_n, mosi;
  logic       miso;

  logic       start8 = 1'b0;
  logic [7:0] tx8 = 8'h00;
  logic [1:0] mode8 = 2'b00;
  logic [7:0] rx8;
  logic       done8, busy8, sclk8, cs_n8, mosi8, miso8;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_master_driver dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .mode(mode),
    .rx_data(rx_data), .done(done), .busy(busy), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso)
  );

  spi_master_driver #(.CLK_DIV(8), .CS_SETUP(1), .CS_HOLD(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .tx_data(tx8), .mode(mode8),
    .rx_data(rx8), .done(done8), .busy(busy8), .sclk(sclk8), .cs_n(cs_n8),
    .mosi(mosi8), .miso(miso8)
  );

  assign miso8 = mosi8;

  // Behavioural SPI slave, evaluated on the falling clk edge so it never races the master
  logic [1:0] s_mode = 2'b00;
  logic [7:0] s_resp = 8'h00;
  logic [7:0] s_tx, s_rx;
  logic       s_miso = 1'b0;
  logic       s_prev_cs = 1'b1;
  logic       s_prev_sclk = 1'b0;
  int         s_edges = 0;
  int         s_aborts = 0;
  logic [7:0] s_recq[$];

  assign miso = s_miso;

  always @(negedge clk) begin
    if (s_prev_cs && !cs_n) begin
      s_edges = 0;
      s_rx = 8'h00;
      s_tx = s_resp;
      if (!s_mode[0]) begin
        s_miso = s_resp[7];
        s_tx = {s_resp[6:0], 1'b0};
      end
    end else if (!cs_n && (sclk != s_prev_sclk)) begin
      s_edges++;
      if ((sclk != s_mode[1]) == !s_mode[0]) s_rx = {s_rx[6:0], mosi};
      else begin
        s_miso = s_tx[7];
        s_tx = {s_tx[6:0], 1'b0};
      end
    end else if (!s_prev_cs && cs_n) begin
      if (s_edges == 16) s_recq.push_back(s_rx);
      else s_aborts++;
    end
    s_prev_cs = cs_n;
    s_prev_sclk = sclk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_slave(input string tag, input logic [7:0] exp);
    logic [7:0] v;
    check_val({tag, "_slv_cnt"}, 32'(s_recq.size()), 32'd1);
    if (s_recq.size() > 0) begin
      v = s_recq.pop_front();
      check_val({tag, "_slv_rx"}, 32'(v), 32'(exp));
    end
  endtask

  task automatic do_frame(input string tag, input logic [1:0] m, input logic [7:0] tx,
                          input logic [7:0] resp, input bit intrude);
    int low, edges, extra, busy_drop;
    logic prev;
    s_mode = m; s_resp = resp; mode = m; tx_data = tx; start = 1'b1;
    tick();
    start = 1'b0;
    check_val({tag, "_cs_fall"}, 32'(cs_n), 32'd0);
    check_val({tag, "_busy_set"}, 32'(busy), 32'd1);
    check_val({tag, "_sclk_pre"}, 32'(sclk), 32'(m[1]));
    low = 1; edges = 0; busy_drop = 0; extra = 0; prev = sclk;
    for (int i = 0; i < 400 && !done; i++) begin
      if (intrude && i == 20) begin
        start = 1'b1; tx_data = 8'hEE; mode = ~m;
      end else start = 1'b0;
      tick();
      if (sclk !== prev) edges++;
      prev = sclk;
      if (cs_n === 1'b0) low++;
      if (busy !== 1'b1 && !done) busy_drop++;
    end
    start = 1'b0;
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_cs_low_len"}, 32'(low), 32'd68);
    check_val({tag, "_sclk_edges"}, 32'(edges), 32'd16);
    check_val({tag, "_rx_data"}, 32'(rx_data), 32'(resp));
    check_val({tag, "_sclk_post"}, 32'(sclk), 32'(m[1]));
    check_val({tag, "_busy_clr"}, 32'(busy), 32'd0);
    if (intrude) check_val({tag, "_busy_hold"}, 32'(busy_drop), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) extra++;
    end
    check_val({tag, "_no_extra_done"}, 32'(extra), 32'd0);
    check_val({tag, "_cs_idle"}, 32'(cs_n), 32'd1);
    check_slave(tag, tx);
  endtask

  initial begin
    logic [7:0] b2b [3];
    int nd, edges, cnt;
    logic prev, prev_done;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cs_n", 32'(cs_n), 32'd1);
    check_val("rst_sclk", 32'(sclk), 32'd0);
    check_val("rst_mosi", 32'(mosi), 32'd0);
    check_val("rst_rx_data", 32'(rx_data), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    do_frame("m0", 2'b00, 8'hA5, 8'h3C, 1'b0);
    do_frame("m1", 2'b01, 8'h81, 8'h7E, 1'b0);
    do_frame("m2", 2'b10, 8'h81, 8'h7E, 1'b0);
    do_frame("m3", 2'b11, 8'h81, 8'h7E, 1'b0);

    // back-to-back: start held high across three frames
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55;
    s_mode = 2'b00; s_resp = 8'h96; mode = 2'b00; tx_data = b2b[0]; start = 1'b1;
    tick();
    nd = 0; prev_done = 1'b0;
    for (int i = 0; i < 400 && nd < 3; i++) begin
      tick();
      if (prev_done) check_val("b2b_gap", 32'(cs_n), 32'd0);
      prev_done = done;
      if (done) begin
        nd++;
        check_val("b2b_cs_high", 32'(cs_n), 32'd1);
        check_val("b2b_rx", 32'(rx_data), 32'h96);
        if (nd < 3) tx_data = b2b[nd];
        else start = 1'b0;
      end
    end
    start = 1'b0;
    check_val("b2b_done_cnt", 32'(nd), 32'd3);
    tick(); tick();
    check_val("b2b_slv_cnt", 32'(s_recq.size()), 32'd3);
    for (int i = 0; i < 3 && s_recq.size() > 0; i++) begin
      prev = 1'b0;
      check_val("b2b_slv_rx", 32'(s_recq.pop_front()), 32'(b2b[i]));
    end

    do_frame("intr", 2'b00, 8'h3C, 8'hC3, 1'b1);

    // reset after e7
    s_mode = 2'b00; s_resp = 8'h11; mode = 2'b00; tx_data = 8'hF0; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0; prev = sclk;
    for (int i = 0; i < 200 && edges < 7; i++) begin
      tick();
      if (sclk !== prev) edges++;
      prev = sclk;
    end
    check_val("rst_mid_e7", 32'(edges), 32'd7);
    rst = 1'b1;
    #1;
    check_val("rst_mid_cs_n", 32'(cs_n), 32'd1);
    check_val("rst_mid_sclk", 32'(sclk), 32'd0);
    check_val("rst_mid_busy", 32'(busy), 32'd0);
    check_val("rst_mid_done", 32'(done), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check_val("rst_mid_done_after", 32'(done), 32'd0);
    check_val("rst_mid_abort", 32'(s_aborts), 32'd1);
    check_val("rst_mid_no_rec", 32'(s_recq.size()), 32'd0);
    do_frame("post_rst", 2'b00, 8'h5A, 8'hC6, 1'b0);

    // CLK_DIV=8, CS_SETUP=1, CS_HOLD=3, mode 3, mosi looped to miso
    mode8 = 2'b11; tx8 = 8'hC3; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check_val("d8_cs_fall", 32'(cs_n8), 32'd0);
    check_val("d8_sclk_pre", 32'(sclk8), 32'd1);
    cnt = 0; prev = sclk8;
    for (int i = 0; i < 100 && sclk8 === prev; i++) begin
      tick();
      cnt++;
    end
    check_val("d8_first_edge", 32'(cnt), 32'd9);
    edges = 1; prev = sclk8;
    for (int i = 0; i < 400 && edges < 16; i++) begin
      tick();
      if (sclk8 !== prev) edges++;
      prev = sclk8;
    end
    check_val("d8_edges", 32'(edges), 32'd16);
    cnt = 0;
    for (int i = 0; i < 50 && !done8; i++) begin
      tick();
      cnt++;
    end
    check_val("d8_done_delay", 32'(cnt), 32'd3);
    check_val("d8_rx", 32'(rx8), 32'hC3);
    check_val("d8_cs_rise", 32'(cs_n8), 32'd1);
    check_val("d8_sclk_post", 32'(sclk8), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_driver.md
Name: spi_master_driver

Overview:
- Full-duplex SPI master that drives sclk, cs_n and mosi and samples miso.
- Counterpart of the SPI slave driver; used in the DDS control path to talk to SPI peripherals, and in simulation to exercise the slave driver.
- Each start request sends one 8-bit frame, MSB first, and returns the received byte with a one-cycle done pulse.
- Supports SPI modes 0-3, selected per transfer.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period. Minimum 4, so the slave's 2-flop edge detect plus miso update settles before the master samples.
- CS_SETUP, 2: clk cycles from cs_n falling to the first sclk edge. Minimum 1.
- CS_HOLD, 2: clk cycles from the last sclk edge to cs_n rising. Minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle transfer request; accepted only when busy=0
- tx_data  input  8  byte to send; captured on an accepted start
- mode  input  2  {CPOL,CPHA}; captured on an accepted start
- rx_data  output  8  received byte; valid from the done pulse until the next done
- done  output  1  one-cycle pulse at the end of a frame
- busy  output  1  high from the cycle after an accepted start until done
- sclk  output  1  SPI clock
- cs_n  output  1  chip select, active low
- mosi  output  1  master out
- miso  input  1  master in; sampled directly, no synchroniser (same clk domain as the slave in this design)

Behaviour:
Reset:
- Reset is asynchronous.
- Outputs: state=IDLE, sclk=0, cs_n=1, mosi=0, rx_data=0, done=0, busy=0.
- Asserting reset mid-frame aborts the frame immediately, with no done pulse.

State machine and timing (cycle 0 = start sampled high in IDLE):
- IDLE, start=1:
  - Latch tx_data into shift_tx and mode into mode_q.
  - Cycle 1: cs_n=0, busy=1, sclk=CPOL, mosi=tx_data[7].
  - Go to SETUP.
- SETUP: lasts CS_SETUP cycles, then go to XFER.
- XFER:
  - 16 half-periods of CLK_DIV cycles each.
  - sclk toggles on the last cycle of each half-period, giving edges e1..e16.
  - Odd edges are leading edges; even edges are trailing edges.
  - CPHA=0:
    - Sample miso into rx shift (MSB first) on leading edges.
    - Shift mosi to the next bit on trailing edges e2..e14.
    - Hold mosi after e16.
  - CPHA=1:
    - Drive mosi with the next bit on leading edges; e1 drives bit7.
    - Sample miso on trailing edges.
  - Sampling registers miso in the same clk cycle the sclk edge is registered.
  - After e16, sclk is back at CPOL. Go to HOLD.
- HOLD:
  - Lasts CS_HOLD cycles.
  - On the last HOLD cycle, the next edge sets cs_n=1, busy=0, done=1, rx_data=rx shift. Go to IDLE.
- Frame length from cs_n falling to cs_n rising: CS_SETUP + 16*CLK_DIV + CS_HOLD cycles.

Boundary conditions:
- start while busy=1 is ignored. No queueing, no error flag.
- start in the same cycle as done (busy=0) is accepted. cs_n is then high for exactly 1 cycle between frames.
- mode or tx_data changes during a frame have no effect.
- Bit counter: 4 bits. Edge counter: 0..15.
- Divider counter: ceil(log2(CLK_DIV)) bits, wraps at CLK_DIV-1, held at 0 outside XFER.
- sclk never glitches. When cs_n=1, sclk is 0 after reset and CPOL of the last frame otherwise. On start it is set to the new CPOL in cycle 1, before any edge.

Decomposition:
- Shared package spi_pkg:
  - Constants SPI_MODE0..SPI_MODE3 (2'b00..2'b11).
  - State encodings ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD.
  - SPI_FRAME_BITS=8.
- One natural sub-module, spi_sclk_gen:
  - Contains the divider counter and the edge counter.
  - Outputs sclk, lead_pulse, trail_pulse, last_edge.
  - Enabled in XFER; reloads CPOL when idle.

Test Plan:
- Mode 0, CLK_DIV=4, tx_data=0xA5, looped to a slave driver (mode 0, response_data=0x3C):
  - Slave rec_data=0xA5 with rec_done pulse.
  - Master rx_data=0x3C with done pulse.
  - cs_n low for exactly 2+64+2 = 68 cycles.
- Modes 1, 2 and 3 with the same loopback, tx=0x81 and response=0x7E:
  - Both sides correct.
  - sclk idles at CPOL before and after the frame.
  - Exactly 16 sclk edges per frame.
- Back-to-back: start held high for 3 frames (0x00, 0xFF, 0x55):
  - 3 done pulses.
  - cs_n high exactly 1 cycle between frames.
  - All bytes received correctly by the slave.
- start pulsed mid-frame with tx=0xEE:
  - Ignored; current frame completes unchanged.
  - No extra done; busy stays high.
- rst asserted after edge e7:
  - Same cycle: cs_n=1, sclk=0, busy=0, done stays 0.
  - A fresh 0x5A frame after reset transfers correctly.
- CLK_DIV=8, CS_SETUP=1, CS_HOLD=3, mode 3:
  - First sclk edge occurs 1+8 cycles after cs_n falls.
  - done occurs 3 cycles after e16.
